// File: rtl/sram_array.sv
// rtl/sram_array.sv - DEPTH x N synchronous SRAM bank with registered read, bit-masked write and hardware clear
module sram_array #(
  parameter int N      = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      data_in,
  input  logic [N-1:0]      wmask,
  input  logic              clear_req,
  output logic              rd_valid,
  output logic [N-1:0]      data_out,
  output logic              init_busy
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [N-1:0]      r_mem [DEPTH];
  logic              r_rd_valid;
  logic [N-1:0]      r_data_out;

  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic              w_in_range;
  logic              w_cnt_last;
  logic [N-1:0]      w_rd_data;

  assign w_accept   = req_valid & req_ready;
  assign w_wr       = w_accept & req_write;
  assign w_rd       = w_accept & ~req_write;
  assign w_in_range = ({1'b0, addr} < LP_DEPTH);
  assign w_cnt_last = (r_cnt == LP_LAST);
  assign w_rd_data  = w_in_range ? r_mem[addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (w_cnt_last) w_state_nxt = ST_READY;
      ST_READY: if (clear_req)  w_state_nxt = ST_INIT;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    init_busy = (r_state == ST_INIT);
    req_ready = (r_state == ST_READY) && !clear_req;
  end

  // Counter parks at 0 in READY so a clear always restarts from row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Array carries no reset; zero contents come only from the INIT sweep.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr && w_in_range) begin
      r_mem[addr] <= (r_mem[addr] & ~wmask) | (data_in & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_data_out <= w_rd_data;
    end
  end

  assign rd_valid = r_rd_valid;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_sram_array.sv
// tb/tb_sram_array.sv - directed self-checking bench for sram_array (DEPTH=16 and DEPTH=12 instances)
module tb_sram_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req_valid, a_req_write, a_clear_req;
  logic [3:0] a_addr;
  logic [7:0] a_data_in, a_wmask;
  logic       a_req_ready, a_rd_valid, a_init_busy;
  logic [7:0] a_data_out;
  logic       b_req_valid, b_req_write;
  logic [3:0] b_addr;
  logic [7:0] b_data_in, b_wmask;
  logic       b_req_ready, b_rd_valid, b_init_busy;
  logic [7:0] b_data_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_array #(.N(8), .DEPTH(16), .ADDR_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .addr(a_addr), .data_in(a_data_in), .wmask(a_wmask),
    .clear_req(a_clear_req), .rd_valid(a_rd_valid), .data_out(a_data_out),
    .init_busy(a_init_busy)
  );

  sram_array #(.N(8), .DEPTH(12), .ADDR_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .addr(b_addr), .data_in(b_data_in), .wmask(b_wmask),
    .clear_req(1'b0), .rd_valid(b_rd_valid), .data_out(b_data_out),
    .init_busy(b_init_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_req_valid = 1'b0; a_req_write = 1'b0; a_addr = '0; a_data_in = '0; a_wmask = '0;
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [7:0] d, input logic [7:0] m);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_addr = ad; a_data_in = d; a_wmask = m;
    tick();
    a_idle();
  endtask

  task automatic a_rd(input logic [3:0] ad);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_addr = ad;
    tick();
    a_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  16'(a_init_busy), 16'h1);
    chk({tag, "_ready"}, 16'(a_req_ready), 16'h0);
    chk({tag, "_rdv"},   16'(a_rd_valid),  16'h0);
    chk({tag, "_dout"},  16'(a_data_out),  16'h0);
  endtask

  task automatic chk_init_16(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy"}, 16'(a_init_busy), 16'h1);
      tick();
    end
    chk({tag, "_done_busy"}, 16'(a_init_busy), 16'h0);
    chk({tag, "_done_ready"}, 16'(a_req_ready), 16'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear_req = 1'b0;
    a_idle();
    b_req_valid = 1'b0; b_req_write = 1'b0; b_addr = '0; b_data_in = '0; b_wmask = '0;
    #3;
    chk_reset_outputs("por");
    tick();
    tick();
    rst_n = 1'b1;
    chk_init_16("init");

    // every row reads zero, back-to-back, one rd_valid per accept
    for (int r = 0; r < 16; r++) begin
      a_req_valid = 1'b1; a_req_write = 1'b0; a_addr = 4'(r);
      tick();
      chk("init_rdv", 16'(a_rd_valid), 16'h1);
      chk("init_row", 16'(a_data_out), 16'h00);
    end
    a_idle();
    tick();
    chk("rdv_drop", 16'(a_rd_valid), 16'h0);

    a_wr(4'd3, 8'hFF, 8'hFF);
    chk("wr_no_rdv", 16'(a_rd_valid), 16'h0);
    a_wr(4'd3, 8'h00, 8'h0F);
    a_rd(4'd3);
    chk("mask_rdv", 16'(a_rd_valid), 16'h1);
    chk("mask_row3", 16'(a_data_out), 16'hF0);
    tick();
    chk("mask_rdv_once", 16'(a_rd_valid), 16'h0);
    chk("mask_hold", 16'(a_data_out), 16'hF0);

    a_wr(4'd7, 8'hA5, 8'hFF);
    a_rd(4'd7);
    chk("b2b_rdv", 16'(a_rd_valid), 16'h1);
    chk("b2b_row7", 16'(a_data_out), 16'hA5);
    a_wr(4'd7, 8'hFF, 8'h00);
    chk("wr_hold_dout", 16'(a_data_out), 16'hA5);
    a_rd(4'd7);
    chk("nomask_row7", 16'(a_data_out), 16'hA5);

    // drop req_valid with no accept: nothing happens
    a_req_valid = 1'b0; a_addr = 4'd7;
    tick();
    chk("noreq_rdv", 16'(a_rd_valid), 16'h0);

    for (int r = 0; r < 16; r++) a_wr(4'(r), 8'(8'h10 + r), 8'hFF);
    a_rd(4'd5);
    chk("fill_row5", 16'(a_data_out), 16'h15);
    a_rd(4'd15);
    chk("fill_row15", 16'(a_data_out), 16'h1F);

    // clear collides with a write: write refused, full sweep, mid-INIT clear ignored
    a_clear_req = 1'b1;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_addr = 4'd0; a_data_in = 8'h77; a_wmask = 8'hFF;
    #1;
    chk("clr_ready_low", 16'(a_req_ready), 16'h0);
    tick();
    a_clear_req = 1'b0;
    a_idle();
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", 16'(a_init_busy), 16'h1);
      chk("clr_ready", 16'(a_req_ready), 16'h0);
      a_clear_req = (i == 3);
      tick();
    end
    a_clear_req = 1'b0;
    chk("clr_done_busy", 16'(a_init_busy), 16'h0);
    chk("clr_done_ready", 16'(a_req_ready), 16'h1);
    chk("clr_dout_hold", 16'(a_data_out), 16'h1F);
    for (int r = 0; r < 16; r++) begin
      a_req_valid = 1'b1; a_req_write = 1'b0; a_addr = 4'(r);
      tick();
      chk("clr_rdv", 16'(a_rd_valid), 16'h1);
      chk("clr_row", 16'(a_data_out), 16'h00);
    end
    a_idle();

    // DEPTH=12 instance: out-of-range write dropped, read returns zero
    b_req_valid = 1'b1; b_req_write = 1'b1; b_addr = 4'd1; b_data_in = 8'h11; b_wmask = 8'hFF;
    tick();
    b_addr = 4'd13; b_data_in = 8'h5A;
    tick();
    b_req_write = 1'b0; b_addr = 4'd1;
    tick();
    chk("oor_row1", 16'(b_data_out), 16'h11);
    b_addr = 4'd13;
    tick();
    chk("oor_rdv", 16'(b_rd_valid), 16'h1);
    chk("oor_rd13", 16'(b_data_out), 16'h00);
    for (int r = 0; r < 12; r++) begin
      b_addr = 4'(r);
      tick();
      chk("oor_row", 16'(b_data_out), (r == 1) ? 16'h11 : 16'h00);
    end
    b_req_valid = 1'b0;

    // reset asserted mid-traffic, between edges
    a_wr(4'd9, 8'h99, 8'hFF);
    a_rd(4'd9);
    chk("pre_rst_dout", 16'(a_data_out), 16'h99);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_traffic");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midinit_busy", 16'(a_init_busy), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_init");
    tick();
    rst_n = 1'b1;
    chk_init_16("reinit");
    a_rd(4'd9);
    chk("reinit_row9", 16'(a_data_out), 16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
